mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles in REQ+WAIT before abort with error.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core issues load/store.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load data shifted to bit 0, unextended; feeds the downstream extender.
REQ-012 resp_err  output  1  misaligned/illegal/timeout, qualified by resp_valid.
REQ-013 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-014 mem_addr  output  32  word address, bits [1:0]=00.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  lane-steered store data.
REQ-017 mem_gnt, mem_rvalid  input  1 each  request accepted; read data valid.
REQ-018 mem_rdata  input  32  raw memory word.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 Accept on req_valid&&req_ready; latch we, funct3, addr, wdata into holding registers; next state REQ.
REQ-021 Illegal funct3 (x11, 11x), half with addr[0]=1, or word with addr[1:0]!=00: no memory request; next state RESP with resp_err=1.
REQ-022 REQ: mem_req=1, all mem_* outputs stable until mem_gnt; on gnt a store goes to RESP, a load goes to WAIT.
REQ-023 WAIT: mem_req=0; on mem_rvalid capture mem_rdata>>(8*addr[1:0]) into resp_rdata; go to RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request is accepted no earlier than the next cycle.
REQ-025 Minimum latency with gnt and rvalid same cycle as asserted: store 2 cycles accept-to-resp_valid, load 3.
REQ-026 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; mem_be=0 when mem_req=0.
REQ-027 mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-028 Timeout counter clears on entry to REQ and counts in REQ/WAIT; reaching TIMEOUT_CYCLES drops mem_req, goes to RESP with resp_err=1.
REQ-029 mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
REQ-030 resp_rdata holds its value until the next load capture; stores do not modify it.

Reset
REQ-031 rst_n low: state IDLE, mem_req=0, mem_we=0, mem_be=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, holding registers 0, immediately and asynchronously.
REQ-032 Reset during REQ/WAIT abandons the access with no resp_valid; a late mem_rvalid after reset is ignored.

Structure
REQ-033 Shared package mem_pkg holds the state enum, funct3 size localparams, and the misalignment function.
REQ-034 Combinational sub-module mem_lane_align computes mem_be, mem_wdata, and read shift from funct3 and addr[1:0]; FSM and counter live in mem_access_unit.

Verification
REQ-035 Load word addr 0x100, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF -> mem_be=1111, mem_addr=0x100, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-036 Store byte addr 0x203, wdata 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200, resp_valid 2 cycles after accept.
REQ-037 Load half funct3=101, addr 0x42, rdata 0x1234ABCD -> mem_be=1100, resp_rdata=0x00001234.
REQ-038 Load word addr 0x101 -> mem_req never asserted, resp_valid with resp_err=1 one cycle after accept.
REQ-039 Load with mem_gnt held low, TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles, resp_err=1, req_ready returns.
REQ-040 rst_n pulsed low in WAIT, then mem_rvalid -> no resp_valid, state IDLE, req_ready=1.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, RV32 load/store size codes and the access legality check
package mem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Flags both unknown size codes and accesses that straddle their natural alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        illegal = (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11);
        return illegal || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable, store lane steering and load shift from size code and address low bits
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  rshift_o
);
    always_comb begin
        be_o     = funct3_i[1:0] == F3_B[1:0] ? 4'b0001 << addr_lo_i :
                   funct3_i[1:0] == F3_H[1:0] ? 4'b0011 << addr_lo_i : 4'b1111;
        wdata_o  = funct3_i[1:0] == F3_B[1:0] ? {4{wdata_i[7:0]}} :
                   funct3_i[1:0] == F3_H[1:0] ? {2{wdata_i[15:0]}} : wdata_i;
        rshift_o = {addr_lo_i, 3'b000};
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store bridge from core requests to a gnt/rvalid memory port
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  lane_be;
    logic [4:0]  rshift;
    logic        timeout;

    mem_lane_align u_align (
        .funct3_i (f3_q),
        .addr_lo_i(addr_q[1:0]),
        .wdata_i  (wdata_q),
        .be_o     (lane_be),
        .wdata_o  (mem_wdata),
        .rshift_o (rshift)
    );

    assign timeout    = cnt_q == TO_LAST;
    assign req_ready  = state_q == S_IDLE;
    assign mem_req    = state_q == S_REQ;
    assign mem_we     = mem_req & we_q;
    assign mem_be     = mem_req ? lane_be : 4'b0000;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign resp_valid = state_q == S_RESP;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = misaligned(req_funct3, req_addr[1:0]);
                cnt_d   = '0;
                state_d = err_d ? S_RESP : S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT;
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata >> rshift;
                    state_d = S_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with a response scoreboard checked by an independent monitor
module tb_mem_access_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [2:0] req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;

    typedef struct {logic err; logic [31:0] rd; int lat;} exp_t;
    exp_t q[$];
    int n_vec = 0, n_err = 0, cyc = 0, acc = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (resp_valid) begin
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: resp_valid=1 with no expected response");
        end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_rdata", resp_rdata, e.rd);
            chk("latency", 32'(cyc - acc), 32'(e.lat));
        end
    end

    // mode 0: normal access, 1: rejected without memory traffic, 2: gnt withheld until timeout
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd, rd,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic eerr,
                       input logic [31:0] erd, input int elat, input int mode, input bit stray);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        acc = cyc;
        q.push_back('{eerr, erd, elat});
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mode == 1) begin
            repeat (2) begin
                @(negedge clk);
                chk("no_mem_req", 32'(mem_req), 32'd0);
            end
        end else if (mode == 2) begin
            n = 0;
            repeat (20) begin
                @(negedge clk);
                if (mem_req) n++;
            end
            chk("timeout_req_cycles", 32'(n), 32'd16);
            chk("ready_after_timeout", 32'(req_ready), 32'd1);
        end else begin
            @(negedge clk);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(we));
            chk("mem_be", 32'(mem_be), 32'(ebe));
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (we) chk("mem_wdata", mem_wdata, ewd);
            mem_gnt = 1'b1;
            if (stray) begin mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!we) begin
                @(negedge clk);
                chk("wait_mem_req", 32'(mem_req), 32'd0);
                chk("wait_mem_be", 32'(mem_be), 32'd0);
                mem_rvalid = 1'b1; mem_rdata = rd;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        chk("resp_drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #8;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        #4 rst_n = 1'b1;
        //  we   f3      addr          wdata         mem rdata     be       exp wdata     err   exp rdata     lat mode stray
        run(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF, 3, 0, 1'b0);
        run(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,       4'b1000, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF, 2, 0, 1'b0);
        run(1'b0, 3'b101, 32'h0000_0042, 32'h0,        32'h1234_ABCD, 4'b1100, 32'h0,        1'b0, 32'h0000_1234, 3, 0, 1'b0);
        run(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_1234, 1, 1, 1'b0);
        run(1'b1, 3'b001, 32'h0000_0046, 32'h0000_BEEF, 32'h0,       4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0000_1234, 2, 0, 1'b0);
        run(1'b0, 3'b100, 32'h0000_0003, 32'h0,        32'hAB00_0000, 4'b1000, 32'h0,        1'b0, 32'h0000_00AB, 3, 0, 1'b1);
        run(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0,       4'b1111, 32'h1122_3344, 1'b0, 32'h0000_00AB, 2, 0, 1'b0);
        run(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_00AB, 1, 1, 1'b0);
        run(1'b1, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_00AB, 1, 1, 1'b0);
        run(1'b0, 3'b001, 32'h0000_0041, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_00AB, 1, 1, 1'b0);
        run(1'b0, 3'b010, 32'h0000_0080, 32'h0,        32'h0,        4'b1111, 32'h0,        1'b1, 32'h0000_00AB, 17, 2, 1'b0);
        // Abandon a load in its wait phase with an asynchronous reset, then send a stale rvalid.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        chk("async_rst_rdata", resp_rdata, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rdata", resp_rdata, 32'd0);
        run(1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_CD00, 4'b0010, 32'h0,        1'b0, 32'h0000_00CD, 3, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
